// File: rtl/shift_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : shift_frame_controller
// Description : Serial-to-parallel frame assembler. Collects WIDTH valid
//               serial bits in a selectable bit order, presents the frame
//               on PO with a valid/ready handshake, and flags overrun when
//               serial data arrives while a completed frame is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_frame_controller #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             START,
  input  logic             MSB_FIRST,
  input  logic             SI,
  input  logic             SI_VALID,
  input  logic             PO_READY,
  output logic [WIDTH-1:0] PO,
  output logic             PO_VALID,
  output logic             SHIFT_EN,
  output logic             LEFT_RIGHT,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             pov_q, pov_d;
  logic             lr_q, lr_d;
  logic             ovr_q, ovr_d;

  logic             w_start_acc;
  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_sr_shifted;

  // State register
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: counter, shift register, frame output, flags
  always_ff @(posedge C) begin
    if (R) begin
      cnt_q <= '0;
      sr_q  <= '0;
      po_q  <= '0;
      pov_q <= 1'b0;
      lr_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      po_q  <= po_d;
      pov_q <= pov_d;
      lr_q  <= lr_d;
      ovr_q <= ovr_d;
    end
  end

  // Next-state and datapath next-value logic
  always_comb begin
    // START is honoured in IDLE and SHIFT; in DONE only together with PO_READY
    w_start_acc = START && ((state_q == S_IDLE) || (state_q == S_SHIFT) ||
                            ((state_q == S_DONE) && PO_READY));
    // START wins over a coincident data bit, so that bit is not shifted
    w_shift      = (state_q == S_SHIFT) && SI_VALID && !START;
    w_last       = w_shift && (cnt_q == C_LAST);
    w_sr_shifted = lr_q ? {SI, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], SI};

    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    po_d    = po_q;
    pov_d   = pov_q;
    lr_d    = lr_q;
    ovr_d   = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (w_start_acc) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_start_acc) state_d = S_SHIFT;
        else if (w_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (w_start_acc)   state_d = S_SHIFT;
        else if (PO_READY) state_d = S_IDLE;
        if (SI_VALID)      ovr_d   = 1'b1;
        if (PO_READY)      pov_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_start_acc) begin
      cnt_d = '0;
      sr_d  = '0;
      lr_d  = !MSB_FIRST;
      ovr_d = 1'b0;
    end else if (w_shift) begin
      sr_d  = w_sr_shifted;
      cnt_d = w_last ? '0 : cnt_q + 1'b1;
      if (w_last) begin
        po_d  = w_sr_shifted;
        pov_d = 1'b1;
      end
    end
  end

  // Outputs decoded from registered state only (SHIFT_EN also uses SI_VALID)
  always_comb begin
    PO         = po_q;
    PO_VALID   = pov_q;
    LEFT_RIGHT = lr_q;
    OVERRUN    = ovr_q;
    BUSY       = (state_q == S_SHIFT);
    SHIFT_EN   = (state_q == S_SHIFT) && SI_VALID && !START && !R;
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_frame_controller
// Description : Directed self-checking bench for shift_frame_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_frame_controller;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       START = 1'b0;
  logic       MSB_FIRST = 1'b0;
  logic       SI = 1'b0;
  logic       SI_VALID = 1'b0;
  logic       PO_READY = 1'b0;
  logic [7:0] PO;
  logic       PO_VALID;
  logic       SHIFT_EN;
  logic       LEFT_RIGHT;
  logic       BUSY;
  logic       OVERRUN;

  int vectors = 0;
  int miscompares = 0;

  shift_frame_controller #(.WIDTH(8)) dut (
    .C          (C),
    .R          (R),
    .START      (START),
    .MSB_FIRST  (MSB_FIRST),
    .SI         (SI),
    .SI_VALID   (SI_VALID),
    .PO_READY   (PO_READY),
    .PO         (PO),
    .PO_VALID   (PO_VALID),
    .SHIFT_EN   (SHIFT_EN),
    .LEFT_RIGHT (LEFT_RIGHT),
    .BUSY       (BUSY),
    .OVERRUN    (OVERRUN)
  );

  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept START with the given bit order; frame is in SHIFT afterwards
  task automatic start_frame(input logic msb);
    START = 1'b1;
    MSB_FIRST = msb;
    tick();
    START = 1'b0;
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
    chk("lr_after_start", {31'd0, LEFT_RIGHT}, {31'd0, !msb});
  endtask

  // One valid serial bit on consecutive cycle
  task automatic send_bit(input logic b);
    SI = b;
    SI_VALID = 1'b1;
    #1;
    chk("shift_en", {31'd0, SHIFT_EN}, 32'd1);
    tick();
    SI_VALID = 1'b0;
  endtask

  // Send n bits of seq, seq[7] first in time
  task automatic send_bits(input logic [7:0] seq, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(seq[i]);
  endtask

  task automatic ack();
    PO_READY = 1'b1;
    tick();
    PO_READY = 1'b0;
    chk("pov_after_ack", {31'd0, PO_VALID}, 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_po"}, {24'd0, PO}, 32'd0);
    chk({tag, "_pov"}, {31'd0, PO_VALID}, 32'd0);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, OVERRUN}, 32'd0);
    chk({tag, "_lr"}, {31'd0, LEFT_RIGHT}, 32'd0);
    chk({tag, "_sen"}, {31'd0, SHIFT_EN}, 32'd0);
  endtask

  initial begin
    // Reset
    R = 1'b1;
    tick();
    tick();
    R = 1'b0;
    chk_reset_state("rst");

    // MSB-first frame 0,0,0,1,1,1,1,0 -> 8'h1E
    start_frame(1'b1);
    send_bits(8'b0001_1110, 7);
    chk("msb_pov_early", {31'd0, PO_VALID}, 32'd0);
    chk("msb_po_early", {24'd0, PO}, 32'h00);
    send_bits(8'b0000_0000, 1);
    chk("msb_po", {24'd0, PO}, 32'h1E);
    chk("msb_pov", {31'd0, PO_VALID}, 32'd1);
    chk("msb_busy", {31'd0, BUSY}, 32'd0);
    ack();
    chk("msb_po_held", {24'd0, PO}, 32'h1E);
    tick();

    // LSB-first, same bit sequence -> 8'h78
    start_frame(1'b0);
    for (int i = 7; i >= 0; i--) begin
      send_bit(i == 7 ? 1'b0 : (i >= 1 && i <= 4 ? 1'b1 : 1'b0));
      if (i > 0) chk("lsb_lr", {31'd0, LEFT_RIGHT}, 32'd1);
    end
    chk("lsb_po", {24'd0, PO}, 32'h78);
    chk("lsb_pov", {31'd0, PO_VALID}, 32'd1);
    ack();

    // MSB-first 8'hA5 with 3-cycle gaps after bits 2 and 5
    start_frame(1'b1);
    send_bits(8'b1000_0000, 2);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("gap1_sen", {31'd0, SHIFT_EN}, 32'd0);
      chk("gap1_busy", {31'd0, BUSY}, 32'd1);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("gap2_pov", {31'd0, PO_VALID}, 32'd0);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    chk("gap_pov_early", {31'd0, PO_VALID}, 32'd0);
    send_bit(1'b1);
    chk("gap_po", {24'd0, PO}, 32'hA5);
    chk("gap_pov", {31'd0, PO_VALID}, 32'd1);

    // DONE held 5 cycles with an SI_VALID pulse -> overrun, PO stable
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        SI = 1'b0;
        SI_VALID = 1'b1;
        #1;
        chk("ovr_sen", {31'd0, SHIFT_EN}, 32'd0);
      end
      tick();
      SI_VALID = 1'b0;
      chk("done_po", {24'd0, PO}, 32'hA5);
      chk("done_pov", {31'd0, PO_VALID}, 32'd1);
      chk("done_ovr", {31'd0, OVERRUN}, c >= 2 ? 32'd1 : 32'd0);
    end
    ack();
    chk("ovr_idle", {31'd0, OVERRUN}, 32'd1);
    chk("ovr_idle_po", {24'd0, PO}, 32'hA5);

    // Back-to-back: frame 8'hC3 then START+PO_READY in DONE, frame 8'h3C
    start_frame(1'b1);
    chk("ovr_cleared", {31'd0, OVERRUN}, 32'd0);
    send_bits(8'hC3, 8);
    chk("b2b_po1", {24'd0, PO}, 32'hC3);
    START = 1'b1;
    MSB_FIRST = 1'b1;
    PO_READY = 1'b1;
    tick();
    START = 1'b0;
    PO_READY = 1'b0;
    chk("b2b_busy", {31'd0, BUSY}, 32'd1);
    chk("b2b_pov", {31'd0, PO_VALID}, 32'd0);
    send_bits(8'h3C, 8);
    chk("b2b_po2", {24'd0, PO}, 32'h3C);
    chk("b2b_pov2", {31'd0, PO_VALID}, 32'd1);
    ack();

    // Restart mid-frame: partial bits discarded, direction re-latched
    start_frame(1'b1);
    send_bits(8'hFF, 3);
    start_frame(1'b0);
    send_bits(8'b0001_1110, 8);
    chk("restart_po", {24'd0, PO}, 32'h78);
    ack();

    // Reset after 4 bits, then frame 8'h81
    start_frame(1'b1);
    send_bits(8'hFF, 4);
    R = 1'b1;
    tick();
    R = 1'b0;
    chk_reset_state("midrst");
    tick();
    chk("midrst_pov_quiet", {31'd0, PO_VALID}, 32'd0);
    start_frame(1'b1);
    send_bits(8'h81, 8);
    chk("post_rst_po", {24'd0, PO}, 32'h81);
    chk("post_rst_pov", {31'd0, PO_VALID}, 32'd1);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_frame_controller.md
SHIFT_FRAME_CONTROLLER -- requirements
Module: shift_frame_controller

Interface
REQ-001 Parameter: WIDTH, 8, frame length in bits and width of PO (legal range 2..32).
REQ-002 Port: C  input  1  rising-edge clock; the only clock.
REQ-003 Port: R  input  1  reset; synchronous, active-high, sampled on rising edge of C.
REQ-004 Port: START  input  1  begin a new frame; sampled each rising edge.
REQ-005 Port: MSB_FIRST  input  1  frame bit order; sampled only when START accepted.
REQ-006 Port: SI  input  1  serial data bit; qualified by SI_VALID.
REQ-007 Port: SI_VALID  input  1  SI holds a valid bit this cycle.
REQ-008 Port: PO_READY  input  1  consumer accepts PO this cycle.
REQ-009 Port: PO  output  WIDTH  assembled parallel frame, registered.
REQ-010 Port: PO_VALID  output  1  PO holds a complete frame.
REQ-011 Port: SHIFT_EN  output  1  internal shift register shifts this cycle.
REQ-012 Port: LEFT_RIGHT  output  1  latched shift direction: 0 = left (SI enters bit 0), 1 = right (SI enters bit WIDTH-1).
REQ-013 Port: BUSY  output  1  frame in progress (state SHIFT).
REQ-014 Port: OVERRUN  output  1  sticky error: SI_VALID seen while in state DONE.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE; all outputs registered or decoded from registered state only.
REQ-016 IDLE: START=1 -> SHIFT next cycle; bit counter cleared; LEFT_RIGHT latched as NOT MSB_FIRST; OVERRUN cleared.
REQ-017 IDLE: SI_VALID ignored; no shifting; shift register holds.
REQ-018 SHIFT: SHIFT_EN = SI_VALID (combinational from state and SI_VALID); each such edge shifts SI into internal register per LEFT_RIGHT and increments counter.
REQ-019 SHIFT: cycles with SI_VALID=0 SHALL hold register and counter (gaps allowed, unbounded).
REQ-020 SHIFT: on edge accepting the WIDTH-th bit, shifted result SHALL load PO, PO_VALID set, state -> DONE; PO_VALID high in the next cycle (latency 1 clock from last bit edge).
REQ-021 MSB_FIRST=1: first accepted bit SHALL appear at PO[WIDTH-1]; MSB_FIRST=0: first bit at PO[0].
REQ-022 SHIFT: START=1 SHALL restart the frame (counter cleared, direction re-latched, partial bits discarded); START has priority over a simultaneous SI_VALID.
REQ-023 DONE: PO and PO_VALID held stable until PO_READY=1; on PO_READY edge PO_VALID cleared, state -> IDLE.
REQ-024 DONE: SI_VALID=1 SHALL set OVERRUN; bit discarded; OVERRUN held until R or accepted START.
REQ-025 DONE: START ignored unless PO_READY=1 same cycle, in which case handshake completes and state -> SHIFT directly (back-to-back frames, no IDLE cycle).
REQ-026 Counter width SHALL be ceil(log2(WIDTH)) bits; counter never exceeds WIDTH-1; no wrap outside SHIFT.
REQ-027 PO SHALL change only on frame completion or R.

Reset
REQ-028 R=1 SHALL override all inputs, taking effect at the next rising edge regardless of state.
REQ-029 After reset: state IDLE, counter 0, shift register 0, PO=0, PO_VALID=0, BUSY=0, OVERRUN=0, LEFT_RIGHT=0, SHIFT_EN=0.
REQ-030 Reset mid-frame or in DONE SHALL discard partial/pending frame without PO_VALID pulse.

Verification
REQ-031 START with MSB_FIRST=1, then bits 0,0,0,1,1,1,1,0 on consecutive SI_VALID cycles -> PO=8'h1E, PO_VALID=1 one cycle after 8th bit, BUSY=0.
REQ-032 Same bits with MSB_FIRST=0 -> PO=8'h78; LEFT_RIGHT=1 throughout SHIFT.
REQ-033 MSB_FIRST=1 frame 8'hA5 with 3-cycle SI_VALID gaps after bits 2 and 5 -> PO=8'hA5; counter frozen during gaps.
REQ-034 PO_READY held 0 for 5 cycles in DONE with SI_VALID pulse -> PO stable, OVERRUN=1 until next START; no extra shifting.
REQ-035 START+PO_READY same cycle in DONE, second frame 8'h3C -> no IDLE cycle, second PO=8'h3C.
REQ-036 R asserted after 4 bits -> next cycle all outputs at reset values; following full frame 8'h81 assembles correctly.
